// File: rtl/sender_pkg.sv
// Shared constants for the sender stage: bus/word geometry defaults,
// FSM state encodings and the beat-count helper.
package sender_pkg;

    localparam int MEM_ADDR_SIZE           = 16;
    localparam int WORD_SIZE_BIT           = 32;
    localparam int BANDWIDTH_WRITE_ADDRESS = 8;

    localparam logic [1:0] SND_IDLE = 2'd0;
    localparam logic [1:0] SND_SEND = 2'd1;
    localparam logic [1:0] SND_GAP  = 2'd2;

    // Number of bus beats needed to carry {addr, data}.
    function automatic int beats_f(input int aw, input int dw, input int bw);
        return (aw + dw + bw - 1) / bw;
    endfunction

endpackage

// File: rtl/sender_if.sv
// Request handshake and narrow-bus signals of the sender stage.
// master: sender view (drives ready/send/bus); slave: requester/receiver view.
interface sender_if #(
    parameter int ADDR_W = sender_pkg::MEM_ADDR_SIZE,
    parameter int DATA_W = sender_pkg::WORD_SIZE_BIT,
    parameter int BUS_W  = sender_pkg::BANDWIDTH_WRITE_ADDRESS
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              send;
    logic              write_out;
    logic [BUS_W-1:0]  bus;
    logic              busy;

    modport master (
        input  req_valid, req_write, req_addr, req_data,
        output req_ready, send, write_out, bus, busy
    );

    modport slave (
        output req_valid, req_write, req_addr, req_data,
        input  req_ready, send, write_out, bus, busy
    );

endinterface

// File: rtl/sender_shift_reg.sv
// Parallel-load register with BUS_W-wide right shift; chunk_o is the low beat.
// Ports: clk, rst_n, load_i, shift_i, data_i[W], chunk_o[BUS_W].
module sender_shift_reg #(
    parameter int W     = 48,
    parameter int BUS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [W-1:0]     data_i,
    output logic [BUS_W-1:0] chunk_o
);

    logic [W-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= sr_q >> BUS_W;
        end
    end

    assign chunk_o = sr_q[BUS_W-1:0];

endmodule

// File: rtl/sender.sv
// Serializes one {addr, data} request onto a narrow bus, LSB beat first,
// framed by send and closed by a one-cycle gap.
// Ports: clk, reset (async, active-low), bus_if (sender_if.master).
// Option: SENDER_SKID_EN adds a one-entry skid buffer for back-to-back frames.
module sender
    import sender_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_SIZE,
    parameter int DATA_W = WORD_SIZE_BIT,
    parameter int BUS_W  = BANDWIDTH_WRITE_ADDRESS
) (
    input logic      clk,
    input logic      reset,
    sender_if.master bus_if
);

    localparam int BEATS = beats_f(ADDR_W, DATA_W, BUS_W);
    localparam int PKT_W = BEATS * BUS_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             wr_q, wr_d;
    logic             accept;
    logic             ready;
    logic             load;
    logic             shift;
    logic [PKT_W-1:0] pkt_in;
    logic [PKT_W-1:0] load_pkt;
    logic [BUS_W-1:0] chunk;

    // Upper bits zero-padded when BUS_W does not divide ADDR_W+DATA_W.
    assign pkt_in = PKT_W'({bus_if.req_addr, bus_if.req_data});
    assign accept = bus_if.req_valid && ready;

`ifdef SENDER_SKID_EN
    logic             skid_full_q, skid_full_d;
    logic [PKT_W-1:0] skid_pkt_q, skid_pkt_d;
    logic             skid_wr_q, skid_wr_d;
    logic             take_req;

    assign ready = !skid_full_q;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        wr_d        = wr_q;
        load        = 1'b0;
        shift       = 1'b0;
        load_pkt    = pkt_in;
        take_req    = 1'b0;
        skid_full_d = skid_full_q;
        skid_pkt_d  = skid_pkt_q;
        skid_wr_d   = skid_wr_q;
        unique case (state_q)
            SND_IDLE: begin
                if (accept) begin
                    take_req = 1'b1;
                    load     = 1'b1;
                    wr_d     = bus_if.req_write;
                    beat_d   = '0;
                    state_d  = SND_SEND;
                end
            end
            SND_SEND: begin
                shift  = 1'b1;
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST) begin
                    beat_d  = '0;
                    state_d = SND_GAP;
                end
            end
            SND_GAP: begin
                state_d = SND_IDLE;
                wr_d    = 1'b0;
                if (skid_full_q) begin
                    // Drain the waiting entry straight into a new frame.
                    load        = 1'b1;
                    load_pkt    = skid_pkt_q;
                    wr_d        = skid_wr_q;
                    skid_full_d = 1'b0;
                    state_d     = SND_SEND;
                end else if (accept) begin
                    take_req = 1'b1;
                    load     = 1'b1;
                    wr_d     = bus_if.req_write;
                    state_d  = SND_SEND;
                end
            end
            default: begin
                state_d = SND_IDLE;
            end
        endcase
        if (accept && !take_req) begin
            skid_full_d = 1'b1;
            skid_pkt_d  = pkt_in;
            skid_wr_d   = bus_if.req_write;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_full_q <= 1'b0;
            skid_pkt_q  <= '0;
            skid_wr_q   <= 1'b0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_pkt_q  <= skid_pkt_d;
            skid_wr_q   <= skid_wr_d;
        end
    end
`else
    assign ready = (state_q == SND_IDLE);

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        wr_d     = wr_q;
        load     = 1'b0;
        shift    = 1'b0;
        load_pkt = pkt_in;
        unique case (state_q)
            SND_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    wr_d    = bus_if.req_write;
                    beat_d  = '0;
                    state_d = SND_SEND;
                end
            end
            SND_SEND: begin
                shift  = 1'b1;
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST) begin
                    beat_d  = '0;
                    state_d = SND_GAP;
                end
            end
            SND_GAP: begin
                wr_d    = 1'b0;
                state_d = SND_IDLE;
            end
            default: begin
                state_d = SND_IDLE;
            end
        endcase
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SND_IDLE;
            beat_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wr_q    <= wr_d;
        end
    end

    sender_shift_reg #(
        .W     (PKT_W),
        .BUS_W (BUS_W)
    ) u_shift (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (load_pkt),
        .chunk_o (chunk)
    );

    // All outputs derive from registers only.
    assign bus_if.send      = (state_q == SND_SEND);
    assign bus_if.bus       = bus_if.send ? chunk : '0;
    assign bus_if.write_out = wr_q;
    assign bus_if.busy      = (state_q != SND_IDLE);
    assign bus_if.req_ready = ready;

endmodule

// File: tb/tb_sender.sv
// Directed self-checking bench for sender: default geometry plus a
// BUS_W=10 instance for the padded last beat.
module tb_sender;

    logic clk;
    logic reset;

    int n_chk;
    int n_fail;

`ifdef SENDER_SKID_EN
    localparam int   PERIOD   = 7;
    localparam logic SEND_RDY = 1'b1;
`else
    localparam int   PERIOD   = 8;
    localparam logic SEND_RDY = 1'b0;
`endif

    sender_if #(.ADDR_W(16), .DATA_W(32), .BUS_W(8))  ifa ();
    sender_if #(.ADDR_W(16), .DATA_W(32), .BUS_W(10)) ifb ();

    sender #(.ADDR_W(16), .DATA_W(32), .BUS_W(8)) dut_a (
        .clk    (clk),
        .reset  (reset),
        .bus_if (ifa.master)
    );

    sender #(.ADDR_W(16), .DATA_W(32), .BUS_W(10)) dut_b (
        .clk    (clk),
        .reset  (reset),
        .bus_if (ifb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and check every beat, the gap and return.
    task automatic do_frame(input logic [15:0] a, input logic [31:0] d,
                            input logic w, input string tag);
        logic [47:0] p;
        logic [47:0] rx;
        p  = {a, d};
        rx = '0;
        chk({tag, "_rdy_idle"}, ifa.req_ready, 1'b1);
        ifa.req_valid = 1'b1;
        ifa.req_write = w;
        ifa.req_addr  = a;
        ifa.req_data  = d;
        step();
        ifa.req_valid = 1'b0;
        ifa.req_write = ~w;
        ifa.req_addr  = ~a;
        ifa.req_data  = ~d;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("%s_send%0d", tag, k), ifa.send, 1'b1);
            chk($sformatf("%s_bus%0d", tag, k), ifa.bus, p[k*8 +: 8]);
            chk($sformatf("%s_wr%0d", tag, k), ifa.write_out, w);
            rx[k*8 +: 8] = ifa.bus;
            if (k < 5) step();
        end
        chk({tag, "_rdy_send"}, ifa.req_ready, SEND_RDY);
        step();
        chk({tag, "_gap_send"}, ifa.send, 1'b0);
        chk({tag, "_gap_bus"}, ifa.bus, 8'h00);
        chk({tag, "_gap_wr"}, ifa.write_out, w);
        chk({tag, "_rx_addr"}, rx[47:32], a);
        chk({tag, "_rx_data"}, rx[31:0], d);
        step();
        chk({tag, "_idle_rdy"}, ifa.req_ready, 1'b1);
        chk({tag, "_idle_wr"}, ifa.write_out, 1'b0);
        chk({tag, "_idle_busy"}, ifa.busy, 1'b0);
    endtask

    initial begin
        int acc;
        int rises;
        int rise_t[3];
        logic prev;
        logic [49:0] pb;

        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        ifa.req_valid = 1'b0;
        ifa.req_write = 1'b0;
        ifa.req_addr  = '0;
        ifa.req_data  = '0;
        ifb.req_valid = 1'b0;
        ifb.req_write = 1'b0;
        ifb.req_addr  = '0;
        ifb.req_data  = '0;

        repeat (3) step();
        chk("rst_send", ifa.send, 1'b0);
        chk("rst_bus", ifa.bus, 8'h00);
        chk("rst_wr", ifa.write_out, 1'b0);
        chk("rst_busy", ifa.busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_rst_rdy", ifa.req_ready, 1'b1);

        do_frame(16'h1234, 32'hDEADBEEF, 1'b1, "wr");
        do_frame(16'h00FF, 32'h0, 1'b0, "rd");

        // Three requests with valid held high.
        ifa.req_write = 1'b1;
        ifa.req_addr  = 16'hA5A5;
        ifa.req_data  = 32'h0102_0304;
        ifa.req_valid = 1'b1;
        acc   = 0;
        rises = 0;
        prev  = 1'b0;
        for (int c = 0; c < 60 && rises < 3; c++) begin
            if (ifa.req_valid && ifa.req_ready) acc++;
            step();
            if (acc == 3) ifa.req_valid = 1'b0;
            if (ifa.send && !prev) begin
                rise_t[rises] = c;
                rises++;
            end
            prev = ifa.send;
        end
        ifa.req_valid = 1'b0;
        chk("b2b_frames", rises, 3);
        if (rises == 3) begin
            chk("b2b_period1", rise_t[1] - rise_t[0], PERIOD);
            chk("b2b_period2", rise_t[2] - rise_t[1], PERIOD);
        end
        for (int c = 0; c < 40 && ifa.busy; c++) step();
        chk("b2b_drain", ifa.busy, 1'b0);
        step();

        // Reset in the middle of a frame.
        ifa.req_valid = 1'b1;
        ifa.req_write = 1'b1;
        ifa.req_addr  = 16'hFFFF;
        ifa.req_data  = 32'hFFFF_FFFF;
        step();
        ifa.req_valid = 1'b0;
        step();
        step();
        chk("mid_bus2", ifa.bus, 8'hFF);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_send", ifa.send, 1'b0);
        chk("mid_rst_bus", ifa.bus, 8'h00);
        chk("mid_rst_wr", ifa.write_out, 1'b0);
        chk("mid_rst_busy", ifa.busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("mid_post_rdy", ifa.req_ready, 1'b1);
        do_frame(16'h5A5A, 32'hCAFE_F00D, 1'b1, "after_rst");

        // BUS_W=10: five beats, last beat carries only 8 valid bits.
        pb = {2'b00, 16'hFFFF, 32'hFFFF_FFFF};
        ifb.req_valid = 1'b1;
        ifb.req_write = 1'b0;
        ifb.req_addr  = 16'hFFFF;
        ifb.req_data  = 32'hFFFF_FFFF;
        step();
        ifb.req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("b10_send%0d", k), ifb.send, 1'b1);
            chk($sformatf("b10_bus%0d", k), ifb.bus, pb[k*10 +: 10]);
            step();
        end
        chk("b10_gap_send", ifb.send, 1'b0);
        chk("b10_gap_bus", ifb.bus, 10'h000);
        step();
        chk("b10_idle_rdy", ifb.req_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
